// File: rtl/io_bus_sequencer_pkg.sv
// Shared types and default timing for the I/O bus sequencer.
// State encodings are 3-bit so they match the I/O interface bench decode.
package io_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_CNT_W         = 4;

  typedef struct packed {
    logic busy;
    logic ack;
    logic err;
    logic rd_capture;
    logic address_ld_n;
    logic data_ld_n;
    logic idle_n;
    logic dir_out;
    logic word;
    logic select_dev;
    logic rd;
    logic wr;
  } bus_ctrl_t;

  function automatic bus_ctrl_t ctrl_idle();
    bus_ctrl_t c;
    c              = '0;
    c.address_ld_n = 1'b1;
    c.data_ld_n    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/io_bus_sequencer_if.sv
// CPU request / I/O interface control bundle for the sequencer.
// master = request source (CPU side), slave = the sequencer itself.
interface io_bus_sequencer_if;
  logic req;
  logic req_write;
  logic req_word;
  logic req_dev;
  logic req_addr0;
  logic busy;
  logic ack;
  logic err;
  logic rd_capture;
  logic address_ld_n;
  logic data_ld_n;
  logic idle_n;
  logic dir_out;
  logic word;
  logic select_dev;
  logic rd;
  logic wr;

  modport master (
    output req, req_write, req_word, req_dev, req_addr0,
    input  busy, ack, err, rd_capture, address_ld_n, data_ld_n,
           idle_n, dir_out, word, select_dev, rd, wr
  );

  modport slave (
    input  req, req_write, req_word, req_dev, req_addr0,
    output busy, ack, err, rd_capture, address_ld_n, data_ld_n,
           idle_n, dir_out, word, select_dev, rd, wr
  );
endinterface

// File: rtl/io_wait_counter.sv
// Wait-state down-counter: synchronous load, decrement that saturates at 0,
// and a zero flag used by the sequencer to leave timed states.
module io_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/io_bus_sequencer.sv
// I/O bus sequencer: turns a one-cycle CPU request into the load / setup /
// strobe / hold control sequence with programmable wait states.
//
// state  | meaning
// IDLE   | waiting for req; unaligned word request answered with err
// LOAD   | address (and write-data) register load strobes
// SETUP  | bus driven, direction/size/space valid, no strobe yet
// STROBE | rd or wr asserted; rd_capture in the final read cycle
// HOLD   | strobe released, bus still driven
// DONE   | ack to CPU, bus released
module io_bus_sequencer
  import io_bus_sequencer_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input logic            clock,
  input logic            reset,
  io_bus_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_t       state_q, state_d;
  logic             write_q, word_q, dev_q;
  logic             write_n, word_n, dev_n;
  logic             accept, reject;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             cnt_next_zero;
  bus_ctrl_t        ctrl_q, ctrl_d;

  io_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      dev_q   <= 1'b0;
      ctrl_q  <= ctrl_idle();
    end else begin
      state_q <= state_d;
      write_q <= write_n;
      word_q  <= word_n;
      dev_q   <= dev_n;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (bus.req_word && bus.req_addr0) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        state_d  = ST_SETUP;
        cnt_load = 1'b1;
        cnt_val  = SETUP_LD;
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_STROBE;
          cnt_load = 1'b1;
          cnt_val  = STROBE_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin is a flop.
  always_comb begin
    write_n = accept ? bus.req_write : write_q;
    word_n  = accept ? bus.req_word  : word_q;
    dev_n   = accept ? bus.req_dev   : dev_q;

    if (cnt_load)     cnt_next_zero = (cnt_val == '0);
    else if (cnt_dec) cnt_next_zero = (cnt == CNT_ONE);
    else              cnt_next_zero = cnt_zero;

    ctrl_d      = ctrl_idle();
    ctrl_d.busy = (state_d != ST_IDLE);
    ctrl_d.err  = reject;
    ctrl_d.ack  = (state_d == ST_DONE);
    if (state_d == ST_LOAD) begin
      ctrl_d.address_ld_n = 1'b0;
      ctrl_d.data_ld_n    = ~write_n;
    end
    if ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) begin
      ctrl_d.idle_n     = 1'b1;
      ctrl_d.dir_out    = write_n;
      ctrl_d.word       = word_n;
      ctrl_d.select_dev = dev_n;
    end
    if (state_d == ST_STROBE) begin
      ctrl_d.rd         = ~write_n;
      ctrl_d.wr         = write_n;
      ctrl_d.rd_capture = ~write_n & cnt_next_zero;
    end
  end

  assign bus.busy         = ctrl_q.busy;
  assign bus.ack          = ctrl_q.ack;
  assign bus.err          = ctrl_q.err;
  assign bus.rd_capture   = ctrl_q.rd_capture;
  assign bus.address_ld_n = ctrl_q.address_ld_n;
  assign bus.data_ld_n    = ctrl_q.data_ld_n;
  assign bus.idle_n       = ctrl_q.idle_n;
  assign bus.dir_out      = ctrl_q.dir_out;
  assign bus.word         = ctrl_q.word;
  assign bus.select_dev   = ctrl_q.select_dev;
  assign bus.rd           = ctrl_q.rd;
  assign bus.wr           = ctrl_q.wr;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Self-checking bench: instance A uses default timing, instance B uses
// setup=2/strobe=3/hold=2. Ack timing is scoreboarded, outputs traced per cycle.
module tb_io_bus_sequencer;

  localparam int SA = 1, TA = 2, HA = 1;
  localparam int SB = 2, TB = 3, HB = 2;
  localparam logic [11:0] RST_VEC = 12'b0000_1100_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   q_a[$];
  int   q_b[$];

  io_bus_sequencer_if bus_a ();
  io_bus_sequencer_if bus_b ();

  io_bus_sequencer #(.SETUP_CYCLES(SA), .STROBE_CYCLES(TA), .HOLD_CYCLES(HA), .CNT_W(4))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  io_bus_sequencer #(.SETUP_CYCLES(SB), .STROBE_CYCLES(TB), .HOLD_CYCLES(HB), .CNT_W(4))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // {busy, ack, err, rd_capture, address_ld_n, data_ld_n, idle_n, dir_out, word, select_dev, rd, wr}
  function automatic logic [11:0] get_vec(bit inst_b);
    if (inst_b)
      return {bus_b.busy, bus_b.ack, bus_b.err, bus_b.rd_capture, bus_b.address_ld_n,
              bus_b.data_ld_n, bus_b.idle_n, bus_b.dir_out, bus_b.word, bus_b.select_dev,
              bus_b.rd, bus_b.wr};
    return {bus_a.busy, bus_a.ack, bus_a.err, bus_a.rd_capture, bus_a.address_ld_n,
            bus_a.data_ld_n, bus_a.idle_n, bus_a.dir_out, bus_a.word, bus_a.select_dev,
            bus_a.rd, bus_a.wr};
  endfunction

  // k = 1 is the first cycle after the edge that sampled req.
  function automatic logic [11:0] exp_vec(int k, int s, int st, int h,
                                          logic w, logic wd, logic dv);
    logic busy, ack, rdc, aln, dln, idn, dir, wo, sd, rd, wr;
    int   done_k;
    done_k = 2 + s + st + h;
    busy = (k >= 1) && (k <= done_k);
    ack  = (k == done_k);
    aln  = !(k == 1);
    dln  = !((k == 1) && w);
    idn = 0; dir = 0; wo = 0; sd = 0; rd = 0; wr = 0; rdc = 0;
    if (k >= 2 && k < done_k) begin
      idn = 1; dir = w; wo = wd; sd = dv;
    end
    if (k >= 2 + s && k < 2 + s + st) begin
      rd = !w; wr = w;
      rdc = !w && (k == 1 + s + st);
    end
    return {busy, ack, 1'b0, rdc, aln, dln, idn, dir, wo, sd, rd, wr};
  endfunction

  task automatic drive_req(bit inst_b, logic r, logic w, logic wd, logic dv, logic a0);
    if (inst_b) begin
      bus_b.req = r; bus_b.req_write = w; bus_b.req_word = wd;
      bus_b.req_dev = dv; bus_b.req_addr0 = a0;
    end else begin
      bus_a.req = r; bus_a.req_write = w; bus_a.req_word = wd;
      bus_a.req_dev = dv; bus_a.req_addr0 = a0;
    end
  endtask

  // Scoreboard pop on every ack, plus the strobe-exclusivity / stability checks.
  logic prev_act_a = 0, prev_act_b = 0;
  logic [2:0] prev_attr_a = 0, prev_attr_b = 0;
  always @(negedge clock) begin
    if (reset) begin
      prev_act_a = 0; prev_act_b = 0;
    end else begin
      if (bus_a.ack) begin
        total++;
        if (q_a.size() == 0) begin
          bad++; $display("FAIL ack_a_unexpected cyc=%0d", cyc);
        end else begin
          int e;
          e = q_a.pop_front();
          if (cyc !== e) begin
            bad++; $display("FAIL ack_a_timing got cyc=%0d want cyc=%0d", cyc, e);
          end
        end
      end
      if (bus_b.ack) begin
        total++;
        if (q_b.size() == 0) begin
          bad++; $display("FAIL ack_b_unexpected cyc=%0d", cyc);
        end else begin
          int e;
          e = q_b.pop_front();
          if (cyc !== e) begin
            bad++; $display("FAIL ack_b_timing got cyc=%0d want cyc=%0d", cyc, e);
          end
        end
      end
      total++;
      if ((bus_a.rd & bus_a.wr) !== 1'b0 || (bus_b.rd & bus_b.wr) !== 1'b0) begin
        bad++; $display("FAIL rd_wr_overlap a=%b%b b=%b%b want no overlap",
                        bus_a.rd, bus_a.wr, bus_b.rd, bus_b.wr);
      end
      total++;
      if (prev_act_a && (bus_a.rd | bus_a.wr) &&
          {bus_a.word, bus_a.select_dev, bus_a.dir_out} !== prev_attr_a) begin
        bad++; $display("FAIL stable_a got %b want %b",
                        {bus_a.word, bus_a.select_dev, bus_a.dir_out}, prev_attr_a);
      end
      total++;
      if (prev_act_b && (bus_b.rd | bus_b.wr) &&
          {bus_b.word, bus_b.select_dev, bus_b.dir_out} !== prev_attr_b) begin
        bad++; $display("FAIL stable_b got %b want %b",
                        {bus_b.word, bus_b.select_dev, bus_b.dir_out}, prev_attr_b);
      end
      prev_act_a  = bus_a.rd | bus_a.wr;
      prev_act_b  = bus_b.rd | bus_b.wr;
      prev_attr_a = {bus_a.word, bus_a.select_dev, bus_a.dir_out};
      prev_attr_b = {bus_b.word, bus_b.select_dev, bus_b.dir_out};
    end
  end

  task automatic run_access(bit inst_b, logic w, logic wd, logic dv, logic a0, string name);
    int s, st, h, n0, done_k;
    logic [11:0] obs, exp;
    s  = inst_b ? SB : SA;
    st = inst_b ? TB : TA;
    h  = inst_b ? HB : HA;
    done_k = 2 + s + st + h;
    @(posedge clock); #1;
    drive_req(inst_b, 1'b1, w, wd, dv, a0);
    n0 = cyc;
    if (inst_b) q_b.push_back(n0 + done_k);
    else        q_a.push_back(n0 + done_k);
    @(posedge clock); #1;
    drive_req(inst_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clock);
      obs = get_vec(inst_b);
      exp = exp_vec(k, s, st, h, w, wd, dv);
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL %s k=%0d got %b want %b", name, k, obs, exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    repeat (2) @(posedge clock);
    #1;
    obs = get_vec(1'b0);
    total++;
    if (obs !== RST_VEC) begin
      bad++; $display("FAIL reset_a got %b want %b", obs, RST_VEC);
    end
    obs = get_vec(1'b1);
    total++;
    if (obs !== RST_VEC) begin
      bad++; $display("FAIL reset_b got %b want %b", obs, RST_VEC);
    end
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_read_default();
    run_access(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "read_def");
    run_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "write_def");
  endtask

  task automatic test_timed();
    run_access(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "write_timed");
    run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "read_timed");
  endtask

  task automatic test_unaligned();
    logic [11:0] obs, exp;
    @(posedge clock); #1;
    drive_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clock); #1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      obs = get_vec(1'b0);
      exp = (k == 1) ? (RST_VEC | 12'b0010_0000_0000) : RST_VEC;
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL unaligned k=%0d got %b want %b", k, obs, exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_abort();
    logic [11:0] obs;
    @(posedge clock); #1;
    drive_req(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    q_a.push_back(cyc + 2 + SA + TA + HA);
    @(posedge clock); #1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if (bus_a.wr !== 1'b1) begin
      bad++; $display("FAIL abort_in_strobe wr got %b want 1", bus_a.wr);
    end
    #2;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    #1;
    obs = get_vec(1'b0);
    total++;
    if (obs !== RST_VEC) begin
      bad++; $display("FAIL abort_async got %b want %b", obs, RST_VEC);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clock);
    run_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int n0, loads, guard;
    @(posedge clock); #1;
    drive_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n0 = cyc;
    q_a.push_back(n0 + 6);
    q_a.push_back(n0 + 13);
    q_a.push_back(n0 + 20);
    loads = 0;
    guard = 0;
    while (cyc < n0 + 21 && guard < 100) begin
      @(negedge clock);
      if (bus_a.address_ld_n === 1'b0) loads++;
      @(posedge clock); #1;
      guard++;
    end
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (guard >= 100) begin
      bad++; $display("FAIL b2b_timeout cycles=%0d", guard);
    end
    repeat (10) @(posedge clock);
    total++;
    if (loads !== 3) begin
      bad++; $display("FAIL b2b_loads got %0d want 3", loads);
    end
    // Pulses on B while it is busy must not start a second access.
    @(posedge clock); #1;
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    q_b.push_back(cyc + 2 + SB + TB + HB);
    @(posedge clock); #1;
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      @(posedge clock); #1;
      drive_req(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (20) @(posedge clock);
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_read_default();
    test_timed();
    test_unaligned();
    test_reset_abort();
    test_back_to_back();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++; $display("FAIL missing_acks got a=%0d b=%0d pending want 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
